// File: rtl/enable_gen_multi.sv
// N_CH-channel programmable tick generator (off / periodic / one-shot / passthrough per channel).
// Define ENABLE_GEN_SYNC_EN to add the sync_clr input that phase-aligns every channel.
module enable_gen_multi #(
    parameter  int N_CH        = 4,
    parameter  int CNT_W       = 16,
    parameter  int DEFAULT_DIV = 9,
    localparam int SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
`ifdef ENABLE_GEN_SYNC_EN
    input  logic              sync_clr,
`endif
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   trig,
    input  logic              cfg_we,
    input  logic [SEL_W-1:0]  cfg_sel,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   busy
);

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_PASS     = 2'b11
    } mode_e;

    logic sync_hit;
    logic sel_ok;

`ifdef ENABLE_GEN_SYNC_EN
    assign sync_hit = sync_clr;
`else
    assign sync_hit = 1'b0;
`endif

    assign sel_ok = (int'(cfg_sel) < N_CH);

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        mode_e            mode_in;
        mode_e            mode_q;
        mode_e            mode_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic [CNT_W-1:0] div_act_q;
        logic [CNT_W-1:0] div_act_d;
        logic [CNT_W-1:0] div_pend_q;
        logic [CNT_W-1:0] div_pend_d;
        logic [CNT_W-1:0] pend_val;
        logic             pend_vld_q;
        logic             pend_vld_d;
        logic             busy_q;
        logic             busy_d;
        logic             tick_q;
        logic             tick_d;
        logic             wr_hit;
        logic             wrap;
        logic             apply;

        assign mode_in  = mode_e'(mode[2*ch +: 2]);
        assign wr_hit   = cfg_we && sel_ok && (int'(cfg_sel) == ch);
        // A write landing on an apply point takes effect at once, so it governs the very next period.
        assign pend_val = wr_hit ? cfg_div : div_pend_q;
        assign wrap     = (cnt_q == div_act_q);

        always_comb begin
            mode_d     = mode_q;
            cnt_d      = cnt_q;
            busy_d     = busy_q;
            tick_d     = 1'b0;
            div_act_d  = div_act_q;
            div_pend_d = div_pend_q;
            pend_vld_d = pend_vld_q;
            apply      = 1'b0;

            if (wr_hit) begin
                div_pend_d = cfg_div;
                pend_vld_d = 1'b1;
            end

            if (sync_hit) begin
                cnt_d = '0;
                apply = 1'b1;
            end else if (mode_in != mode_q) begin
                mode_d = mode_in;
                cnt_d  = '0;
                busy_d = 1'b0;
                apply  = 1'b1;
            end else begin
                case (mode_q)
                    MODE_OFF: begin
                        cnt_d  = '0;
                        busy_d = 1'b0;
                        apply  = 1'b1;
                    end
                    MODE_PERIODIC: begin
                        if (wrap) begin
                            cnt_d  = '0;
                            tick_d = 1'b1;
                            apply  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    MODE_ONESHOT: begin
                        // A trigger arriving while busy, even on the completion edge, is dropped.
                        if (busy_q) begin
                            if (wrap) begin
                                cnt_d  = '0;
                                tick_d = 1'b1;
                                busy_d = 1'b0;
                                apply  = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end else begin
                            cnt_d = '0;
                            apply = 1'b1;
                            if (trig[ch]) begin
                                busy_d = 1'b1;
                            end
                        end
                    end
                    MODE_PASS: begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        busy_d = 1'b0;
                        apply  = 1'b1;
                    end
                    default: begin
                        cnt_d = '0;
                    end
                endcase
            end

            if (apply && (wr_hit || pend_vld_q)) begin
                div_act_d  = pend_val;
                pend_vld_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mode_q     <= MODE_OFF;
                cnt_q      <= '0;
                div_act_q  <= CNT_W'(DEFAULT_DIV);
                div_pend_q <= CNT_W'(DEFAULT_DIV);
                pend_vld_q <= 1'b0;
                busy_q     <= 1'b0;
                tick_q     <= 1'b0;
            end else begin
                mode_q     <= mode_d;
                cnt_q      <= cnt_d;
                div_act_q  <= div_act_d;
                div_pend_q <= div_pend_d;
                pend_vld_q <= pend_vld_d;
                busy_q     <= busy_d;
                tick_q     <= tick_d;
            end
        end

        assign tick[ch] = tick_q;
        assign busy[ch] = busy_q;
    end

endmodule

// File: tb/tb_enable_gen_multi.sv
// Self-checking bench for enable_gen_multi: directed scenarios plus randomized traffic against
// a timestamp-based reference model (next tick / one-shot end edge per channel).
module tb_enable_gen_multi;

    localparam int N_CH  = 5;
    localparam int CNT_W = 16;
    localparam int DDIV  = 9;
    localparam int SEL_W = 3;

    logic              clk;
    logic              reset;
    logic              sync_clr;
    logic [2*N_CH-1:0] mode;
    logic [N_CH-1:0]   trig;
    logic              cfg_we;
    logic [SEL_W-1:0]  cfg_sel;
    logic [CNT_W-1:0]  cfg_div;
    logic [N_CH-1:0]   tick;
    logic [N_CH-1:0]   busy;

    int checks = 0;
    int errors = 0;

    int edge_cnt = 0;
    int m_mq   [N_CH];
    int m_div  [N_CH];
    int m_pend [N_CH];
    int m_next [N_CH];
    int m_end  [N_CH];
    bit m_pvld [N_CH];
    bit m_busy [N_CH];
    bit m_tick [N_CH];

    enable_gen_multi #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DDIV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
`ifdef ENABLE_GEN_SYNC_EN
        .sync_clr(sync_clr),
`endif
        .mode    (mode),
        .trig    (trig),
        .cfg_we  (cfg_we),
        .cfg_sel (cfg_sel),
        .cfg_div (cfg_div),
        .tick    (tick),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_mq[c]   = 0;
            m_div[c]  = DDIV;
            m_pend[c] = DDIV;
            m_next[c] = 0;
            m_end[c]  = 0;
            m_pvld[c] = 1'b0;
            m_busy[c] = 1'b0;
            m_tick[c] = 1'b0;
        end
    endfunction

    // Reference: each channel remembers the absolute edge index of its next tick.
    function automatic void model_edge();
        for (int c = 0; c < N_CH; c++) begin
            bit wr;
            bit pany;
            bit take;
            bit changed;
            bit was_busy;
            int pval;
            int md;
            wr       = (cfg_we === 1'b1) && (int'(cfg_sel) == c);
            pval     = wr ? int'(cfg_div) : m_pend[c];
            pany     = wr || m_pvld[c];
            if (wr) begin
                m_pend[c] = int'(cfg_div);
                m_pvld[c] = 1'b1;
            end
            md       = int'(mode[2*c +: 2]);
            was_busy = m_busy[c];
            take     = 1'b0;
            changed  = 1'b0;
            m_tick[c] = 1'b0;
            if (sync_clr === 1'b1) begin
                take = 1'b1;
            end else if (md != m_mq[c]) begin
                m_mq[c]   = md;
                m_busy[c] = 1'b0;
                take      = 1'b1;
                changed   = 1'b1;
            end else if (m_mq[c] == 1) begin
                if (edge_cnt == m_next[c]) begin
                    m_tick[c] = 1'b1;
                    take      = 1'b1;
                end
            end else if (m_mq[c] == 2) begin
                if (!was_busy) begin
                    take = 1'b1;
                end else if (edge_cnt == m_end[c]) begin
                    m_tick[c] = 1'b1;
                    m_busy[c] = 1'b0;
                    take      = 1'b1;
                end
            end else begin
                take = 1'b1;
                if (m_mq[c] == 3) m_tick[c] = 1'b1;
            end
            if (take && pany) begin
                m_div[c]  = pval;
                m_pvld[c] = 1'b0;
            end
            if (sync_clr === 1'b1) begin
                m_next[c] = edge_cnt + m_div[c] + 1;
                if (m_busy[c]) m_end[c] = edge_cnt + m_div[c] + 1;
            end else if (m_mq[c] == 1 && (changed || m_tick[c])) begin
                m_next[c] = edge_cnt + m_div[c] + 1;
            end else if (m_mq[c] == 2 && !changed && !was_busy && trig[c]) begin
                m_busy[c] = 1'b1;
                m_end[c]  = edge_cnt + m_div[c] + 1;
            end
        end
        edge_cnt++;
    endfunction

    function automatic logic [N_CH-1:0] model_tick_vec();
        logic [N_CH-1:0] v;
        for (int c = 0; c < N_CH; c++) v[c] = m_tick[c];
        return v;
    endfunction

    function automatic logic [N_CH-1:0] model_busy_vec();
        logic [N_CH-1:0] v;
        for (int c = 0; c < N_CH; c++) v[c] = m_busy[c];
        return v;
    endfunction

    task automatic clk_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_mode(input int c, input logic [1:0] m);
        mode[2*c +: 2] = m;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        sync_clr = 1'b0;
        mode     = '0;
        trig     = '0;
        cfg_we   = 1'b0;
        cfg_sel  = '0;
        cfg_div  = '0;
        model_reset();
        #2;
        checks++;
        if (tick !== '0) begin
            errors++;
            $display("[TB] FAIL reset_tick got=%b expected=%b", tick, {N_CH{1'b0}});
        end
        checks++;
        if (busy !== '0) begin
            errors++;
            $display("[TB] FAIL reset_busy got=%b expected=%b", busy, {N_CH{1'b0}});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({tick, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_held tick=%b busy=%b expected all zero", tick, busy);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_periodic_default();
        int first_tick = -1;
        int n_ticks    = 0;
        set_mode(0, 2'b01);
        for (int i = 1; i <= 35; i++) begin
            clk_edge();
            checks++;
            if ({tick, busy} !== {model_tick_vec(), model_busy_vec()}) begin
                errors++;
                $display("[TB] FAIL periodic cyc=%0d tick=%b busy=%b expected tick=%b busy=%b",
                         i, tick, busy, model_tick_vec(), model_busy_vec());
            end
            if (tick[0] && first_tick < 0) first_tick = i;
            if (tick[0]) n_ticks++;
        end
        checks++;
        if (first_tick != 11) begin
            errors++;
            $display("[TB] FAIL periodic_first_tick got edge %0d expected 11", first_tick);
        end
        checks++;
        if (n_ticks != 3) begin
            errors++;
            $display("[TB] FAIL periodic_count got %0d expected 3", n_ticks);
        end
    endtask

    task automatic test_oneshot();
        int busy_cycles = 0;
        int tick_at     = -1;
        int n_ticks     = 0;
        set_mode(1, 2'b10);
        cfg_we  = 1'b1;
        cfg_sel = 3'd1;
        cfg_div = 16'd3;
        clk_edge();
        checks++;
        if ({tick, busy} !== {model_tick_vec(), model_busy_vec()}) begin
            errors++;
            $display("[TB] FAIL oneshot_setup tick=%b busy=%b expected tick=%b busy=%b",
                     tick, busy, model_tick_vec(), model_busy_vec());
        end
        cfg_we  = 1'b0;
        trig[1] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            clk_edge();
            checks++;
            if ({tick, busy} !== {model_tick_vec(), model_busy_vec()}) begin
                errors++;
                $display("[TB] FAIL oneshot cyc=%0d tick=%b busy=%b expected tick=%b busy=%b",
                         i, tick, busy, model_tick_vec(), model_busy_vec());
            end
            if (busy[1]) busy_cycles++;
            if (tick[1]) begin
                n_ticks++;
                tick_at = i;
            end
            trig[1] = (i == 1) || (i == 4);
        end
        trig[1] = 1'b0;
        checks++;
        if (busy_cycles != 4) begin
            errors++;
            $display("[TB] FAIL oneshot_busy_len got %0d expected 4", busy_cycles);
        end
        checks++;
        if (tick_at != 5 || n_ticks != 1) begin
            errors++;
            $display("[TB] FAIL oneshot_tick got edge %0d count %0d expected edge 5 count 1", tick_at, n_ticks);
        end
    endtask

    task automatic test_div_write();
        bit found = 1'b0;
        int offs[$];
        int exp_offs[4] = '{10, 15, 20, 25};
        for (int i = 0; i < 20 && !found; i++) begin
            clk_edge();
            checks++;
            if ({tick, busy} !== {model_tick_vec(), model_busy_vec()}) begin
                errors++;
                $display("[TB] FAIL div_wait tick=%b busy=%b expected tick=%b busy=%b",
                         tick, busy, model_tick_vec(), model_busy_vec());
            end
            if (tick[0]) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL div_wait_timeout got no tick[0] expected one within 20 edges");
            return;
        end
        for (int i = 1; i <= 26; i++) begin
            cfg_we  = (i == 1) || (i == 3);
            cfg_sel = (i == 1) ? 3'd7 : 3'd0;
            cfg_div = (i == 1) ? 16'd1 : 16'd4;
            clk_edge();
            cfg_we = 1'b0;
            checks++;
            if ({tick, busy} !== {model_tick_vec(), model_busy_vec()}) begin
                errors++;
                $display("[TB] FAIL div_write cyc=%0d tick=%b busy=%b expected tick=%b busy=%b",
                         i, tick, busy, model_tick_vec(), model_busy_vec());
            end
            if (tick[0]) offs.push_back(i);
        end
        checks++;
        if (offs.size() != 4) begin
            errors++;
            $display("[TB] FAIL div_write_ticks got %0d ticks expected 4", offs.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (offs[j] != exp_offs[j]) begin
                    errors++;
                    $display("[TB] FAIL div_write_offset idx=%0d got %0d expected %0d", j, offs[j], exp_offs[j]);
                end
            end
        end
    endtask

    task automatic test_passthrough();
        int highs = 0;
        set_mode(2, 2'b11);
        for (int i = 1; i <= 6; i++) begin
            clk_edge();
            checks++;
            if ({tick, busy} !== {model_tick_vec(), model_busy_vec()}) begin
                errors++;
                $display("[TB] FAIL pass cyc=%0d tick=%b busy=%b expected tick=%b busy=%b",
                         i, tick, busy, model_tick_vec(), model_busy_vec());
            end
            if (i == 1 && tick[2] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL pass_first got tick[2]=%b expected 0", tick[2]);
            end
            if (i > 1 && tick[2] === 1'b1) highs++;
        end
        checks++;
        if (highs != 5) begin
            errors++;
            $display("[TB] FAIL pass_high got %0d high cycles expected 5", highs);
        end
        set_mode(2, 2'b00);
        clk_edge();
        checks++;
        if (tick[2] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pass_to_off got tick[2]=%b expected 0", tick[2]);
        end
        cfg_we  = 1'b1;
        cfg_sel = 3'd2;
        cfg_div = 16'd0;
        clk_edge();
        cfg_we = 1'b0;
        set_mode(2, 2'b01);
        highs = 0;
        for (int i = 1; i <= 6; i++) begin
            clk_edge();
            checks++;
            if ({tick, busy} !== {model_tick_vec(), model_busy_vec()}) begin
                errors++;
                $display("[TB] FAIL div0 cyc=%0d tick=%b busy=%b expected tick=%b busy=%b",
                         i, tick, busy, model_tick_vec(), model_busy_vec());
            end
            if (i > 1 && tick[2] === 1'b1) highs++;
        end
        checks++;
        if (highs != 5) begin
            errors++;
            $display("[TB] FAIL div0_every_cycle got %0d ticks expected 5", highs);
        end
    endtask

    task automatic test_reset_mid();
        int first_tick = -1;
        trig[1] = 1'b1;
        clk_edge();
        trig[1] = 1'b0;
        clk_edge();
        checks++;
        if (busy[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rmid_busy_before got %b expected 1", busy[1]);
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({tick, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL rmid_async tick=%b busy=%b expected all zero", tick, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({tick, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL rmid_hold tick=%b busy=%b expected all zero", tick, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            clk_edge();
            checks++;
            if ({tick, busy} !== {model_tick_vec(), model_busy_vec()}) begin
                errors++;
                $display("[TB] FAIL rmid_after cyc=%0d tick=%b busy=%b expected tick=%b busy=%b",
                         i, tick, busy, model_tick_vec(), model_busy_vec());
            end
            if (tick[0] && first_tick < 0) first_tick = i;
        end
        checks++;
        if (first_tick != 11) begin
            errors++;
            $display("[TB] FAIL rmid_first_tick got edge %0d expected 11", first_tick);
        end
    endtask

`ifdef ENABLE_GEN_SYNC_EN
    task automatic test_sync_clr();
        int t0[$];
        int t1[$];
        mode = '0;
        clk_edge();
        cfg_we  = 1'b1;
        cfg_sel = 3'd0;
        cfg_div = 16'd3;
        clk_edge();
        cfg_sel = 3'd1;
        cfg_div = 16'd7;
        clk_edge();
        cfg_we = 1'b0;
        set_mode(0, 2'b01);
        repeat (3) clk_edge();
        set_mode(1, 2'b01);
        repeat (5) clk_edge();
        sync_clr = 1'b1;
        clk_edge();
        sync_clr = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            clk_edge();
            checks++;
            if ({tick, busy} !== {model_tick_vec(), model_busy_vec()}) begin
                errors++;
                $display("[TB] FAIL sync cyc=%0d tick=%b busy=%b expected tick=%b busy=%b",
                         i, tick, busy, model_tick_vec(), model_busy_vec());
            end
            if (tick[0]) t0.push_back(i);
            if (tick[1]) t1.push_back(i);
        end
        checks++;
        if (t0.size() != 4 || t0[0] != 4 || t0[1] != 8 || t0[3] != 16) begin
            errors++;
            $display("[TB] FAIL sync_ch0 got %0d ticks first %0d expected ticks at 4,8,12,16",
                     t0.size(), (t0.size() > 0) ? t0[0] : -1);
        end
        checks++;
        if (t1.size() != 2 || t1[0] != 8 || t1[1] != 16) begin
            errors++;
            $display("[TB] FAIL sync_ch1 got %0d ticks first %0d expected ticks at 8,16",
                     t1.size(), (t1.size() > 0) ? t1[0] : -1);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 15) == 0) set_mode(c, 2'($urandom_range(0, 3)));
                trig[c] = ($urandom_range(0, 3) == 0);
            end
            cfg_we  = ($urandom_range(0, 3) == 0);
            cfg_sel = 3'($urandom_range(0, 7));
            cfg_div = 16'($urandom_range(0, 5));
`ifdef ENABLE_GEN_SYNC_EN
            sync_clr = ($urandom_range(0, 31) == 0);
`endif
            clk_edge();
            checks++;
            if ({tick, busy} !== {model_tick_vec(), model_busy_vec()}) begin
                errors++;
                $display("[TB] FAIL random cyc=%0d tick=%b busy=%b expected tick=%b busy=%b",
                         i, tick, busy, model_tick_vec(), model_busy_vec());
            end
        end
        trig     = '0;
        cfg_we   = 1'b0;
        sync_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_periodic_default();
        test_oneshot();
        test_div_write();
        test_passthrough();
        test_reset_mid();
`ifdef ENABLE_GEN_SYNC_EN
        test_sync_clr();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
